// File: rtl/sonic_sysid_pkg.sv
// sonic_sysid_pkg: shared constants for the SONIC system-ID register block.
// Word addresses, CAPABILITY field layout, CONTROL bit indices and a
// byte-lane merge helper used by the byte-writable registers.
package sonic_sysid_pkg;

  // Word addresses on the 4-bit Avalon-MM address bus.
  localparam logic [3:0] ADDR_SYSID      = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP  = 4'd1;
  localparam logic [3:0] ADDR_SCRATCH    = 4'd2;
  localparam logic [3:0] ADDR_UPTIME_LO  = 4'd3;
  localparam logic [3:0] ADDR_UPTIME_HI  = 4'd4;
  localparam logic [3:0] ADDR_CAPABILITY = 4'd5;
  localparam logic [3:0] ADDR_CONTROL    = 4'd6;
  localparam logic [3:0] ADDR_USER_BASE  = 4'd8;

  // CAPABILITY word layout.
  localparam int CAP_NUM_USER_LSB   = 0;
  localparam int CAP_NUM_USER_W     = 4;
  localparam int CAP_UPTIME_W_LSB   = 4;
  localparam int CAP_UPTIME_W_W     = 7;
  localparam int CAP_UPTIME_PRESENT = 11;

  // CONTROL word bits.
  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_FREEZE = 1;

  // Merge new_v into old_v on the byte lanes selected by be.
  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sonic_sysid_uptime.sv
// sonic_sysid_uptime: free-running uptime counter with a coherent 64-bit
// read shadow and the CONTROL register (CLEAR pulse, FREEZE level).
// Only instantiated when SONIC_SYSID_UPTIME_EN is defined.
module sonic_sysid_uptime
  import sonic_sysid_pkg::*;
#(
  parameter int UPTIME_W = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_wr_i,     // accepted write to CONTROL
  input  logic [1:0]  ctrl_wdata_i,  // CONTROL write data bits [1:0]
  input  logic        lo_rd_i,       // accepted read of UPTIME_LO
  output logic [31:0] lo_o,          // live counter[31:0]
  output logic [31:0] hi_o,          // shadow, zero-extended
  output logic [31:0] ctrl_o         // CONTROL readback
);

  localparam int HI_W = UPTIME_W - 32;

  logic [UPTIME_W-1:0] cnt_q, cnt_d;
  logic [HI_W-1:0]     shadow_q, shadow_d;
  logic                freeze_q, freeze_d;
  logic                clear;

  // CLEAR is a write-1 pulse; it never coexists with a LO read because a
  // simultaneous read drops the write upstream.
  assign clear = ctrl_wr_i & ctrl_wdata_i[CTRL_CLEAR];

  // Next state: CLEAR beats FREEZE beats increment; the shadow snapshots the
  // pre-increment upper bits on the same edge the LO word is sampled.
  always_comb begin
    freeze_d = freeze_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (ctrl_wr_i) freeze_d = ctrl_wdata_i[CTRL_FREEZE];
    if (clear) begin
      cnt_d = '0;
    end else if (!freeze_q) begin
      cnt_d = cnt_q + UPTIME_W'(1);
    end
    if (clear) begin
      shadow_d = '0;
    end else if (lo_rd_i) begin
      shadow_d = cnt_q[UPTIME_W-1:32];
    end
  end

  // Counter, shadow and FREEZE registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      freeze_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      freeze_q <= freeze_d;
    end
  end

  // Read-side views: zero-extend the shadow, CLEAR always reads 0.
  always_comb begin
    lo_o                = cnt_q[31:0];
    hi_o                = '0;
    hi_o[HI_W-1:0]      = shadow_q;
    ctrl_o              = '0;
    ctrl_o[CTRL_FREEZE] = freeze_q;
  end

endmodule

// File: rtl/sonic_sysid_regs.sv
// sonic_sysid_regs: system-ID register block, Avalon-MM slave with a
// registered read path (fixed one-cycle latency, no waitrequest).
// Optional uptime counter built when SONIC_SYSID_UPTIME_EN is defined;
// otherwise words 3, 4 and 6 read 0 and ignore writes.
//
// Bus handshake: a read is accepted on every edge where read=1; the data
// appears on readdata with readdatavalid=1 for exactly one cycle after that
// edge, and readdata holds otherwise. A write is accepted when write=1 and
// read=0; a write presented together with a read is dropped.
module sonic_sysid_regs
  import sonic_sysid_pkg::*;
#(
  parameter logic [31:0] SYSID       = 32'd953745243,
  parameter logic [31:0] TIMESTAMP   = 32'd0,
  parameter int          NUM_USER    = 0,
  parameter int          UPTIME_W    = 48,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000,
  localparam int         UW          = (NUM_USER > 0) ? NUM_USER : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [3:0]       byteenable,
  input  logic [UW*32-1:0] user_id,
  output logic [31:0]      readdata,
  output logic             readdatavalid
);

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rd_data;
  logic [31:0] cap;
  logic [31:0] readdata_q;
  logic        rdv_q;
  logic        wr_en;

  // With NUM_USER=0 the single user_id word has no readers.
  logic unused_user;
  assign unused_user = ^user_id;

  assign wr_en = write & ~read;

`ifdef SONIC_SYSID_UPTIME_EN
  logic [31:0] up_lo, up_hi, up_ctrl;

  sonic_sysid_uptime #(
    .UPTIME_W (UPTIME_W)
  ) u_uptime (
    .clock        (clock),
    .reset_n      (reset_n),
    .ctrl_wr_i    (wr_en && (address == ADDR_CONTROL)),
    .ctrl_wdata_i (writedata[1:0]),
    .lo_rd_i      (read && (address == ADDR_UPTIME_LO)),
    .lo_o         (up_lo),
    .hi_o         (up_hi),
    .ctrl_o       (up_ctrl)
  );
`endif

  // CAPABILITY word assembled from build parameters.
  always_comb begin
    cap = '0;
    cap[CAP_NUM_USER_LSB +: CAP_NUM_USER_W] = CAP_NUM_USER_W'(NUM_USER);
    cap[CAP_UPTIME_W_LSB +: CAP_UPTIME_W_W] = CAP_UPTIME_W_W'(UPTIME_W);
`ifdef SONIC_SYSID_UPTIME_EN
    cap[CAP_UPTIME_PRESENT] = 1'b1;
`else
    cap[CAP_UPTIME_PRESENT] = 1'b0;
`endif
  end

  // Read mux: unmapped words and user words beyond NUM_USER read 0.
  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_SYSID:      rd_data = SYSID;
      ADDR_TIMESTAMP:  rd_data = TIMESTAMP;
      ADDR_SCRATCH:    rd_data = scratch_q;
      ADDR_CAPABILITY: rd_data = cap;
`ifdef SONIC_SYSID_UPTIME_EN
      ADDR_UPTIME_LO:  rd_data = up_lo;
      ADDR_UPTIME_HI:  rd_data = up_hi;
      ADDR_CONTROL:    rd_data = up_ctrl;
`endif
      default: begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (address == ADDR_USER_BASE + 4'(k)) rd_data = user_id[k*32 +: 32];
        end
      end
    endcase
  end

  // Scratch next state: byte-lane merge on an accepted write.
  always_comb begin
    scratch_d = scratch_q;
    if (wr_en && (address == ADDR_SCRATCH)) begin
      scratch_d = apply_be(scratch_q, writedata, byteenable);
    end
  end

  // Scratch register and registered read path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q  <= SCRATCH_RST;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rdv_q     <= read;
      if (read) readdata_q <= rd_data;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;

endmodule
